// File: rtl/histo_readout.sv
// histo_readout: reads out the trigger board monitoring histograms.
// On start it steps histostosend through channels 0..NCHAN-1. For each channel
// it waits SETTLE cycles and then latches the eight 32-bit histogram words into
// a shadow register. The channel is sent as a 34-byte frame over a valid/ready
// byte link: header, channel index, then 32 data bytes (word 0 first, each word
// little-endian). An optional one-cycle resethist pulse follows a complete
// readout.
//
// Ports:
//   clk_adc       sole clock, rising edge
//   nrst          asynchronous active-low reset
//   start         readout request (accepted only in IDLE)
//   clear_after   captured with start; request resethist after the last byte
//   histostosend  channel index driven to the histogram block
//   histosin      eight 32-bit histogram words, word k = [32k+31:32k]
//   tx_data       byte to host link
//   tx_valid      tx_data valid
//   tx_ready      host link accepts on tx_valid && tx_ready
//   busy          readout in progress
//   done          one-cycle pulse on return to IDLE after a full readout
//   resethist     one-cycle histogram clear pulse
module histo_readout #(
  parameter int unsigned NCHAN  = 16,
  parameter int unsigned SETTLE = 2,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic         clk_adc,
  input  logic         nrst,
  input  logic         start,
  input  logic         clear_after,
  output logic [7:0]   histostosend,
  input  logic [255:0] histosin,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done,
  output logic         resethist
);

  localparam int unsigned CW = 8;
  localparam int unsigned SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam int unsigned BW = 5;
  localparam int unsigned DW = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LATCH  = 3'd2,
    HDR_B  = 3'd3,
    IDX_B  = 3'd4,
    DATA_B = 3'd5,
    NEXT   = 3'd6,
    CLEAR  = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [BW-1:0]   bcnt_nxt;
  logic            clr_q, clr_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            resethist_q, resethist_d;
  logic            fire;

  // State and output registers.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      settle_q    <= '0;
      bcnt_q      <= '0;
      clr_q       <= 1'b0;
      shadow_q    <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resethist_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      settle_q    <= settle_d;
      bcnt_q      <= bcnt_d;
      clr_q       <= clr_d;
      shadow_q    <= shadow_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resethist_q <= resethist_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered, so the registered tx_data/tx_valid line up with the byte states.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    settle_d    = settle_q;
    bcnt_d      = bcnt_q;
    clr_d       = clr_q;
    shadow_d    = shadow_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    resethist_d = 1'b0;
    fire        = tx_valid_q && tx_ready;
    bcnt_nxt    = bcnt_q + BW'(1);

    case (state_q)
      IDLE: begin
        // The done cycle still counts as leaving the readout, so a start seen
        // together with done is dropped.
        if (start && !done_q) begin
          clr_d    = clear_after;
          chan_d   = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = SELECT;
        end
      end

      SELECT: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = LATCH;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      LATCH: begin
        shadow_d   = histosin;
        tx_data_d  = HDR;
        tx_valid_d = 1'b1;
        state_d    = HDR_B;
      end

      HDR_B: begin
        if (fire) begin
          tx_data_d = chan_q;
          state_d   = IDX_B;
        end
      end

      IDX_B: begin
        if (fire) begin
          bcnt_d    = '0;
          tx_data_d = shadow_q[7:0];
          state_d   = DATA_B;
        end
      end

      DATA_B: begin
        if (fire) begin
          if (bcnt_q == BW'(31)) begin
            bcnt_d     = '0;
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
            state_d    = NEXT;
          end else begin
            bcnt_d    = bcnt_nxt;
            tx_data_d = shadow_q[{bcnt_nxt, 3'b000} +: 8];
          end
        end
      end

      NEXT: begin
        if (chan_q == CW'(NCHAN - 1)) begin
          if (clr_q) begin
            resethist_d = 1'b1;
            state_d     = CLEAR;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          chan_d  = chan_q + CW'(1);
          state_d = SELECT;
        end
      end

      CLEAR: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign histostosend = chan_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign resethist    = resethist_q;

endmodule

// File: tb/tb_histo_readout.sv
// Testbench for histo_readout: randomized backpressure, a registered histogram
// block model and an expected byte stream built from the frame format.
module tb_histo_readout;

  localparam int unsigned NCHAN  = 16;
  localparam int unsigned SETTLE = 2;
  localparam int          FRAME  = 34;
  localparam int          TOTAL  = NCHAN * FRAME;

  logic         clk_adc = 1'b0;
  logic         nrst;
  logic         start;
  logic         clear_after;
  logic [7:0]   histostosend;
  logic [255:0] histosin;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;
  logic         resethist;

  histo_readout #(.NCHAN(NCHAN), .SETTLE(SETTLE), .HDR(8'hA5)) dut (
    .clk_adc      (clk_adc),
    .nrst         (nrst),
    .start        (start),
    .clear_after  (clear_after),
    .histostosend (histostosend),
    .histosin     (histosin),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .resethist    (resethist)
  );

  always #5 clk_adc = ~clk_adc;

  // Histogram block: one-cycle registered output; ovr forces all-ones.
  logic [255:0] histo_reg;
  logic         ovr;
  always @(posedge clk_adc) begin
    for (int k = 0; k < 8; k++)
      histo_reg[32*k +: 32] <= {histostosend, 8'h00, 8'(k), 8'h5A};
  end
  assign histosin = ovr ? '1 : histo_reg;

  int checks   = 0;
  int failures = 0;
  int ready_mode;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int stall_cnt, stall_bad;
  logic prev_stall;
  logic [7:0] prev_data;

  // Results of the last wait_done.
  bit w_ok;
  int w_busy, w_valid, w_rh_n, w_rh, w_done;

  // Host link ready: 0 = always high, 1 = random 30% high, 2 = toggle.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk_adc);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 9) < 3);
        default: tx_ready = ~tx_ready;
      endcase
    end
  end

  // Byte capture and stall-stability tracking.
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    stall_cnt  = 0;
    stall_bad  = 0;
    forever begin
      @(negedge clk_adc);
      if (prev_stall) begin
        stall_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) stall_bad++;
      end
      prev_stall = nrst && tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (nrst && tx_valid && tx_ready) cap_q.push_back(tx_data);
    end
  end

  // Expected byte stream; channels >= ovr_chan carry all-ones data.
  task automatic build_exp(input int ovr_chan);
    logic [31:0] w;
    exp_q.delete();
    for (int c = 0; c < NCHAN; c++) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(c));
      for (int k = 0; k < 8; k++) begin
        w = (32'(c) << 24) | (32'(k) << 8) | 32'h5A;
        for (int b = 0; b < 4; b++)
          exp_q.push_back((c >= ovr_chan) ? 8'hFF : 8'(w >> (8 * b)));
      end
    end
  endtask

  function automatic int first_mismatch();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (cap_q[i] !== exp_q[i]) return i;
    if (cap_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic do_start(input logic clr);
    @(posedge clk_adc);
    #1;
    cap_q.delete();
    stall_cnt   = 0;
    stall_bad   = 0;
    start       = 1'b1;
    clear_after = clr;
    @(posedge clk_adc);
    #1;
    start       = 1'b0;
    clear_after = 1'b0;
  endtask

  // Runs until done (or until stop_at bytes captured); cycle-bounded.
  task automatic wait_done(input int ovr_at, input int stop_at, input int poke_at);
    w_ok = 0; w_busy = -1; w_valid = -1; w_rh_n = 0; w_rh = -1; w_done = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_adc);
      if (poke_at >= 0 && i == poke_at) start = 1'b1;
      if (poke_at >= 0 && i == poke_at + 3) start = 1'b0;
      if (busy && w_busy < 0) w_busy = i;
      if (tx_valid && w_valid < 0) w_valid = i;
      if (resethist) begin w_rh_n++; w_rh = i; end
      if (ovr_at >= 0 && cap_q.size() >= ovr_at) ovr = 1'b1;
      if (stop_at >= 0 && cap_q.size() >= stop_at) begin w_ok = 1; return; end
      if (done) begin w_done = i; w_ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    nrst = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_adc);
      #1;
      start = 1'($urandom);
      clear_after = 1'($urandom);
      @(negedge clk_adc);
      outs = {histostosend, tx_data[0], tx_valid, busy, done | resethist};
      checks++;
      if ({histostosend, tx_data, tx_valid, busy, done, resethist} !== 20'h0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: outputs=%h required 0", i, outs);
      end
    end
    @(posedge clk_adc);
    #1;
    start = 1'b0;
    clear_after = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_adc);
      checks++;
      if ({histostosend, tx_data, tx_valid, busy, done, resethist} !== 20'h0) begin
        failures++;
        $display("FAIL reset_release cycle %0d: busy=%b valid=%b required 0", i, busy, tx_valid);
      end
    end
  endtask

  task automatic test_full();
    int mi;
    ready_mode = 0;
    build_exp(NCHAN);
    do_start(1'b0);
    wait_done(-1, -1, -1);
    checks++;
    if (!w_ok) begin failures++; $display("FAIL full_timeout: done=%b required 1", done); end
    mi = first_mismatch();
    checks++;
    if (mi != -1) begin
      failures++;
      $display("FAIL full_bytes: %0d bytes, first diff at %0d got %h required %h",
               cap_q.size(), mi, (mi < cap_q.size()) ? cap_q[mi] : 8'hxx,
               (mi < exp_q.size()) ? exp_q[mi] : 8'hxx);
    end
    checks++;
    if (cap_q.size() < 3*FRAME + 6 ||
        {cap_q[3*FRAME], cap_q[3*FRAME+1], cap_q[3*FRAME+2],
         cap_q[3*FRAME+3], cap_q[3*FRAME+4], cap_q[3*FRAME+5]} !== 48'hA503_5A00_0003) begin
      failures++;
      $display("FAIL full_chan3_frame: size=%0d required A5 03 5A 00 00 03 at %0d",
               cap_q.size(), 3*FRAME);
    end
    checks++;
    if (w_valid - w_busy != int'(SETTLE) + 1) begin
      failures++;
      $display("FAIL first_valid_latency: got %0d required %0d", w_valid - w_busy, SETTLE + 1);
    end
    checks++;
    if (w_done - w_busy != NCHAN * (SETTLE + 1 + FRAME + 1)) begin
      failures++;
      $display("FAIL full_duration: got %0d required %0d", w_done - w_busy,
               NCHAN * (SETTLE + 1 + FRAME + 1));
    end
    checks++;
    if (w_rh_n != 0) begin failures++; $display("FAIL full_resethist: got %0d pulses required 0", w_rh_n); end
    @(negedge clk_adc);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_done_pulse: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure(input int mode, input string name);
    int mi;
    ready_mode = mode;
    build_exp(NCHAN);
    do_start(1'b0);
    wait_done(-1, -1, -1);
    checks++;
    if (!w_ok) begin failures++; $display("FAIL %s_timeout: done=%b required 1", name, done); end
    mi = first_mismatch();
    checks++;
    if (mi != -1) begin
      failures++;
      $display("FAIL %s_bytes: %0d bytes, first diff at %0d required %0d bytes", name,
               cap_q.size(), mi, TOTAL);
    end
    checks++;
    if (stall_bad != 0 || stall_cnt == 0) begin
      failures++;
      $display("FAIL %s_stall_stable: unstable=%0d of %0d stalls required 0 of >0",
               name, stall_bad, stall_cnt);
    end
  endtask

  task automatic test_snapshot();
    int mi;
    ready_mode = 0;
    build_exp(6);
    ovr = 1'b0;
    do_start(1'b0);
    wait_done(5*FRAME + 2 + 6, -1, -1);
    ovr = 1'b0;
    checks++;
    if (!w_ok) begin failures++; $display("FAIL snapshot_timeout: done=%b required 1", done); end
    mi = first_mismatch();
    checks++;
    if (mi != -1) begin
      failures++;
      $display("FAIL snapshot_bytes: first diff at %0d got %h required %h", mi,
               (mi < cap_q.size()) ? cap_q[mi] : 8'hxx, (mi < exp_q.size()) ? exp_q[mi] : 8'hxx);
    end
    checks++;
    if (cap_q.size() < 6*FRAME + 3 || cap_q[5*FRAME + 33] !== 8'h05 || cap_q[6*FRAME + 2] !== 8'hFF) begin
      failures++;
      $display("FAIL snapshot_edges: size=%0d required ch5 last=05 ch6 first=FF", cap_q.size());
    end
  endtask

  task automatic test_clear();
    int mi;
    ready_mode = 0;
    build_exp(NCHAN);
    do_start(1'b1);
    wait_done(-1, -1, 50);
    checks++;
    if (!w_ok) begin failures++; $display("FAIL clear_timeout: done=%b required 1", done); end
    // start together with done must not begin a new readout
    start = 1'b1;
    @(posedge clk_adc);
    #1;
    start = 1'b0;
    mi = first_mismatch();
    checks++;
    if (mi != -1) begin
      failures++;
      $display("FAIL clear_bytes: %0d bytes, first diff at %0d required %0d bytes", cap_q.size(), mi, TOTAL);
    end
    checks++;
    if (w_rh_n != 1) begin failures++; $display("FAIL clear_pulse_count: got %0d required 1", w_rh_n); end
    checks++;
    if (w_done - w_rh != 1) begin failures++; $display("FAIL clear_done_follow: got %0d required 1", w_done - w_rh); end
    checks++;
    if (w_done - w_busy != NCHAN * (SETTLE + 1 + FRAME + 1) + 1) begin
      failures++;
      $display("FAIL clear_duration: got %0d required %0d", w_done - w_busy,
               NCHAN * (SETTLE + 1 + FRAME + 1) + 1);
    end
    repeat (3) @(negedge clk_adc);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_on_done: busy=%b valid=%b required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_reset_mid();
    int mi;
    ready_mode = 0;
    build_exp(NCHAN);
    do_start(1'b0);
    wait_done(-1, 7*FRAME + 2 + 10, -1);
    checks++;
    if (!w_ok) begin failures++; $display("FAIL reset_mid_reach: bytes=%0d required %0d", cap_q.size(), 7*FRAME + 12); end
    nrst = 1'b0;
    #1;
    checks++;
    if ({histostosend, tx_data, tx_valid, busy, done, resethist} !== 20'h0) begin
      failures++;
      $display("FAIL reset_mid_async: chan=%h data=%h valid=%b busy=%b required 0",
               histostosend, tx_data, tx_valid, busy);
    end
    @(posedge clk_adc);
    #1;
    nrst = 1'b1;
    do_start(1'b0);
    wait_done(-1, -1, -1);
    checks++;
    if (!w_ok || cap_q.size() < 2 || cap_q[0] !== 8'hA5 || cap_q[1] !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_restart: ok=%0d size=%0d required A5 00 first", w_ok, cap_q.size());
    end
    mi = first_mismatch();
    checks++;
    if (mi != -1) begin failures++; $display("FAIL reset_mid_bytes: first diff at %0d required none", mi); end
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    clear_after = 1'b0;
    ovr = 1'b0;
    ready_mode = 1;
    test_reset();
    test_full();
    test_backpressure(1, "backpressure");
    test_backpressure(2, "toggle");
    test_snapshot();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
